mem_cmd_master: RTL and testbench

//  Upstream request master for the single-port memory block. Buffers host commands in a

---
 rtl/mem_cmd_master.sv | 197 +++++++++++++++++++
 tb/tb_mem_cmd_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_cmd_master
// Purpose  : Upstream request master for a single-port memory. Host commands
//            are queued in a small FIFO and issued one at a time as a single
//            valid/wr_rd/addr/wdata transaction. The master then waits for the
//            memory's registered ready and returns a response (read data or
//            write ack) that is held until the host accepts it.
// Ports    : clk_i, rst_i (async, active-high)
//            cmd_*  : host command in (valid/ready, wr_rd, addr, wdata)
//            mem_*  : registered transaction to the memory, ready/rdata back
//            rsp_*  : response out (valid/ready, wr_rd, rdata, err)
//            fifo_count_o : occupied command FIFO entries
// Options  : MEM_MASTER_TIMEOUT_EN - when defined, a WAIT lasting
//            TIMEOUT_CYCLES cycles without mem_ready_i ends in an error
//            response. Otherwise WAIT holds indefinitely and rsp_err_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_cmd_master #(
  parameter int MEMORY_WIDTH   = 8,
  parameter int MEMORY_DEPTH   = 16,
  parameter int ADDRESS_WIDTH  = $clog2(MEMORY_DEPTH),
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic                         cmd_wr_rd_i,
  input  logic [ADDRESS_WIDTH-1:0]     cmd_addr_i,
  input  logic [MEMORY_WIDTH-1:0]      cmd_wdata_i,
  output logic                         mem_valid_o,
  output logic                         mem_wr_rd_o,
  output logic [ADDRESS_WIDTH-1:0]     mem_addr_o,
  output logic [MEMORY_WIDTH-1:0]      mem_wdata_o,
  input  logic                         mem_ready_i,
  input  logic [MEMORY_WIDTH-1:0]      mem_rdata_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic                         rsp_wr_rd_o,
  output logic [MEMORY_WIDTH-1:0]      rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Command FIFO storage (no reset needed: entries are only read when valid)
  logic [FIFO_DEPTH-1:0]    fifo_wr_rd_q;
  logic [ADDRESS_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [MEMORY_WIDTH-1:0]  fifo_wdata_q [FIFO_DEPTH];

  state_t                   state_q;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         count_q;
  logic [CNT_W-1:0]         count_d;

  logic                     mem_valid_q;
  logic                     mem_wr_rd_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [MEMORY_WIDTH-1:0]  mem_wdata_q;
  logic                     rsp_valid_q;
  logic                     rsp_wr_rd_q;
  logic [MEMORY_WIDTH-1:0]  rsp_rdata_q;

  logic                     push;
  logic                     pop;

  // Full blocks new commands even if a pop frees a slot this same cycle.
  assign cmd_ready_o = (count_q != FIFO_FULL) && !rst_i;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_wr_rd_q[wr_ptr_q] <= cmd_wr_rd_i;
      fifo_addr_q[wr_ptr_q]  <= cmd_addr_i;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata_i;
    end
  end

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             rsp_err_q;
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_rd_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEM_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            mem_wr_rd_q <= fifo_wr_rd_q[rd_ptr_q];
            mem_addr_q  <= fifo_addr_q[rd_ptr_q];
            mem_wdata_q <= fifo_wdata_q[rd_ptr_q];
            mem_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_valid_q <= 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
          tmo_q       <= '0;
`endif
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // A ready arriving on the limit edge takes priority over timeout.
          if (mem_ready_i) begin
            rsp_rdata_q <= mem_wr_rd_q ? '0 : mem_rdata_i;
            rsp_wr_rd_q <= mem_wr_rd_q;
            rsp_valid_q <= 1'b1;
`ifdef MEM_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= S_RESP;
          end
`ifdef MEM_MASTER_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            tmo_q       <= tmo_q + 1'b1;
            rsp_rdata_q <= '0;
            rsp_wr_rd_q <= mem_wr_rd_q;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmo_q       <= tmo_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_valid_o  = mem_valid_q;
  assign mem_wr_rd_o  = mem_wr_rd_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_wr_rd_o  = rsp_wr_rd_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign fifo_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_cmd_master
// Purpose  : Self-checking bench for mem_cmd_master. Includes a behavioural
//            single-port memory with registered ready/rdata. A table of
//            single commands checks timing and data; hand-written sequences
//            cover FIFO fill, in-order responses, mid-WAIT reset and (with
//            MEM_MASTER_TIMEOUT_EN) the WAIT timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_cmd_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_wr_rd = 1'b0;
  logic [3:0] cmd_addr  = 4'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       rsp_ready = 1'b1;
  logic       cmd_ready_o;
  logic       mem_valid_o, mem_wr_rd_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic       rsp_valid_o, rsp_wr_rd_o, rsp_err_o;
  logic [7:0] rsp_rdata_o;
  logic [2:0] fifo_count_o;

  // Behavioural memory: ready and rdata registered one cycle after valid.
  logic [7:0] mem_model [16] = '{default: 8'h00};
  logic       mem_ready = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_stall = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= mem_valid_o && !mem_stall;
      if (mem_valid_o) begin
        if (mem_wr_rd_o) mem_model[mem_addr_o] <= mem_wdata_o;
        else             mem_rdata <= mem_model[mem_addr_o];
      end
    end
  end

  int mv_total = 0;
  always @(negedge clk) if (mem_valid_o === 1'b1) mv_total++;

  mem_cmd_master dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_wr_rd_i  (cmd_wr_rd),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .mem_valid_o  (mem_valid_o),
    .mem_wr_rd_o  (mem_wr_rd_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ready_i  (mem_ready),
    .mem_rdata_i  (mem_rdata),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_wr_rd_o  (rsp_wr_rd_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .fifo_count_o (fifo_count_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       exp_wr;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];
  vec_t seq  [5];

  // One command with an idle FIFO and rsp_ready high: checks the one-cycle
  // mem_valid pulse, the issued fields, and the response three edges after push.
  task automatic run_cmd(input vec_t v, input string tag);
    @(negedge clk);
    check({tag, " cmd_ready"}, {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid = 1'b1; cmd_wr_rd = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      check($sformatf("%s mem_valid j=%0d", tag, j), {31'd0, mem_valid_o}, {31'd0, (j == 1)});
      check($sformatf("%s rsp_valid j=%0d", tag, j), {31'd0, rsp_valid_o}, {31'd0, (j == 3)});
      if (j == 1) begin
        check({tag, " mem_addr"},  {28'd0, mem_addr_o},  {28'd0, v.addr});
        check({tag, " mem_wr_rd"}, {31'd0, mem_wr_rd_o}, {31'd0, v.wr});
        if (v.wr) check({tag, " mem_wdata"}, {24'd0, mem_wdata_o}, {24'd0, v.wdata});
      end
      if (j == 3) begin
        check({tag, " rsp_wr_rd"}, {31'd0, rsp_wr_rd_o}, {31'd0, v.exp_wr});
        check({tag, " rsp_rdata"}, {24'd0, rsp_rdata_o}, {24'd0, v.exp_rdata});
        check({tag, " rsp_err"},   {31'd0, rsp_err_o},   32'd0);
      end
    end
  endtask

  initial begin
    int got;
    int cyc;
    int mv_start;
    int stray;
    vec_t rd3;

    vecs[0] = '{1'b1, 4'd3,  8'hA5, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 4'd3,  8'h00, 1'b0, 8'hA5};
    vecs[2] = '{1'b1, 4'd15, 8'h3C, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 4'd0,  8'h00, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 4'd15, 8'h00, 1'b0, 8'h3C};
    vecs[5] = '{1'b1, 4'd9,  8'h5A, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 4'd9,  8'h00, 1'b0, 8'h5A};

    seq[0] = '{1'b1, 4'd4, 8'h11, 1'b1, 8'h00};
    seq[1] = '{1'b1, 4'd5, 8'h22, 1'b1, 8'h00};
    seq[2] = '{1'b0, 4'd4, 8'h00, 1'b0, 8'h11};
    seq[3] = '{1'b0, 4'd5, 8'h00, 1'b0, 8'h22};
    seq[4] = '{1'b0, 4'd3, 8'h00, 1'b0, 8'hA5};

    rd3 = '{1'b0, 4'd3, 8'h00, 1'b0, 8'hA5};

    // ---- Reset state ----
    @(negedge clk);
    check("reset outputs",
          {12'd0, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o, rsp_valid_o,
           rsp_wr_rd_o, rsp_rdata_o, rsp_err_o, fifo_count_o, cmd_ready_o}, 32'd0);
    rst = 1'b0;
    #1;
    check("post-reset cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("post-reset count", {29'd0, fifo_count_o}, 32'd0);

    // ---- Table-driven single commands (7 pushes wrap the 4-entry FIFO) ----
    for (int i = 0; i < 7; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // ---- Fill the FIFO while responses are blocked ----
    rsp_ready = 1'b0;
    mv_start  = mv_total;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("fill cmd_ready %0d", i), {31'd0, cmd_ready_o}, 32'd1);
      cmd_valid = 1'b1; cmd_wr_rd = seq[i].wr; cmd_addr = seq[i].addr; cmd_wdata = seq[i].wdata;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("fill count", {29'd0, fifo_count_o}, 32'd4);
    check("fill cmd_ready low", {31'd0, cmd_ready_o}, 32'd0);
    repeat (6) @(negedge clk);
    #1;
    check("fill single mem_valid", mv_total - mv_start, 32'd1);
    check("fill rsp held", {31'd0, rsp_valid_o}, 32'd1);
    check("fill count held", {29'd0, fifo_count_o}, 32'd4);

    @(negedge clk);
    rsp_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 100) begin
      if (rsp_valid_o) begin
        check($sformatf("order wr_rd %0d", got), {31'd0, rsp_wr_rd_o}, {31'd0, seq[got].exp_wr});
        check($sformatf("order rdata %0d", got), {24'd0, rsp_rdata_o}, {24'd0, seq[got].exp_rdata});
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("order response count", got, 32'd5);
    check("drained count", {29'd0, fifo_count_o}, 32'd0);

    // ---- Reset in the middle of WAIT ----
    mem_stall = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr_rd = 1'b1; cmd_addr = 4'd8; cmd_wdata = 8'h77;
    @(negedge clk);
    cmd_wr_rd = 1'b0; cmd_addr = 4'd3; cmd_wdata = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("wait mem_addr", {28'd0, mem_addr_o}, 32'd8);
    check("wait count", {29'd0, fifo_count_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("async reset outputs",
          {12'd0, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o, rsp_valid_o,
           rsp_wr_rd_o, rsp_rdata_o, rsp_err_o, fifo_count_o, cmd_ready_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_stall = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b0) stray++;
    end
    check("no response after reset", stray, 32'd0);
    run_cmd(rd3, "after-reset");

`ifdef MEM_MASTER_TIMEOUT_EN
    // ---- Timeout: WAIT entered after edge N+2, error after edge N+17 ----
    mem_stall = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr_rd = 1'b0; cmd_addr = 4'd2; cmd_wdata = 8'h00;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int j = 0; j <= 17; j++) begin
      @(negedge clk);
      if (j == 16) check("tmo not yet", {31'd0, rsp_valid_o}, 32'd0);
      if (j == 17) begin
        check("tmo rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        check("tmo rsp_err",   {31'd0, rsp_err_o},   32'd1);
        check("tmo rsp_rdata", {24'd0, rsp_rdata_o}, 32'd0);
      end
    end
    mem_stall = 1'b0;
    @(negedge clk);
    check("tmo rsp accepted", {31'd0, rsp_valid_o}, 32'd0);
    run_cmd(rd3, "after-timeout");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
